// File: rtl/nibble_serial_addsub_if.sv
// Operand/result bundle for the nibble-serial add/sub unit.
// master drives the request side; slave (the adder) drives status and results.
interface nibble_serial_addsub_if #(
   parameter int NIBBLES = 4
);
   localparam int WIDTH = 4 * NIBBLES;

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, result, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, result, cout, ovf
   );
endinterface

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit adder/subtractor, one 4-bit nibble per clock, LSB first.
// Optional signed saturation of the result on overflow: define NIBBLE_ADDSUB_SAT_EN.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | one nibble processed per cycle, busy=1
// FIN   | done pulse, results final, start may be accepted again
module nibble_serial_addsub #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   nibble_serial_addsub_if.slave  bus
);
   localparam int WIDTH = 4 * NIBBLES;
   localparam int CW    = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             sub_r;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] result_r;
   logic             cout_r;
   logic             ovf_r;

   logic             load;
   logic             step;
   logic             last;
   logic [3:0]       bx;
   logic [4:0]       nib;
   logic [3:0]       low3;
   logic             ovf_nx;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] result_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST_CNT) begin
               last     = 1'b1;
               state_nx = FIN;
            end
         end
         FIN: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Subtract is a + ~b + 1: invert b per nibble, initial carry = sub.
   always_comb begin
      bx      = b_sh[3:0] ^ {4{sub_r}};
      nib     = {1'b0, a_sh[3:0]} + {1'b0, bx} + {4'd0, carry};
      low3    = {1'b0, a_sh[2:0]} + {1'b0, bx[2:0]} + {3'd0, carry};
      ovf_nx  = low3[3] ^ nib[4];
      shifted = {nib[3:0], result_r[WIDTH-1:4]};
`ifdef NIBBLE_ADDSUB_SAT_EN
      // On overflow both operands share a sign; a's MSB picks the clamp direction.
      if (last && ovf_nx) begin
         result_nx = a_sh[3] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         result_nx = shifted;
      end
`else
      result_nx = shifted;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         carry    <= 1'b0;
         sub_r    <= 1'b0;
         a_sh     <= '0;
         b_sh     <= '0;
         result_r <= '0;
         cout_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else if (load) begin
         cnt      <= '0;
         carry    <= bus.sub;
         sub_r    <= bus.sub;
         a_sh     <= bus.a;
         b_sh     <= bus.b;
         result_r <= '0;
         cout_r   <= 1'b0;
         ovf_r    <= 1'b0;
      end else if (step) begin
         cnt      <= cnt + 1'b1;
         carry    <= nib[4];
         a_sh     <= a_sh >> 4;
         b_sh     <= b_sh >> 4;
         result_r <= result_nx;
         if (last) begin
            cout_r <= nib[4];
            ovf_r  <= ovf_nx;
         end
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == FIN);
   assign bus.result = result_r;
   assign bus.cout   = cout_r;
   assign bus.ovf    = ovf_r;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub: signed-integer reference model,
// directed corner cases plus random operations; honours NIBBLE_ADDSUB_SAT_EN.
module tb_nibble_serial_addsub;
   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;
   localparam longint MASK = (longint'(1) << W) - 1;
   localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
   localparam longint MINS = -(longint'(1) << (W - 1));

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      int           cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;
   int   run_len;
   exp_t q[$];

   nibble_serial_addsub_if #(.NIBBLES(NIBBLES)) bus ();

   nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t   e;
      longint ua, ub, sa, sb, full, truev;
      ua    = longint'(a);
      ub    = longint'(b);
      sa    = a[W-1] ? ua - (longint'(1) << W) : ua;
      sb    = b[W-1] ? ub - (longint'(1) << W) : ub;
      full  = s ? ua + ((~ub) & MASK) + 1 : ua + ub;
      truev = s ? sa - sb : sa + sb;
      e.res  = W'(full & MASK);
      e.cout = ((full >> W) & 1) != 0;
      e.ovf  = (truev > MAXS) || (truev < MINS);
`ifdef NIBBLE_ADDSUB_SAT_EN
      if (e.ovf) e.res = (truev > MAXS) ? W'(MAXS) : W'(MINS & MASK);
`endif
      e.cyc = 0;
      return e;
   endfunction

   // Monitor: pops one expectation per done pulse and checks latency and values.
   initial run_len = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("result", bus.result, e.res);
               chk("cout", bus.cout, e.cout);
               chk("ovf", bus.ovf, e.ovf);
               chk("done_cycle", cyc, e.cyc);
               chk("busy_len", run_len, NIBBLES);
               chk("busy_in_done", bus.busy, 0);
            end
            run_len = 0;
         end else begin
            if (q.size() != 0 && cyc > q[0].cyc) begin
               chk("done_missing", 0, 1);
               void'(q.pop_front());
            end
            run_len = bus.busy ? run_len + 1 : 0;
         end
      end else begin
         run_len = 0;
      end
   end

   // Waits (bounded) for a cycle where start will be accepted, then issues it.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t e;
      int   n;
      n = 0;
      @(posedge clk); #1;
      while (bus.busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.busy) chk("start_wait_timeout", 1, 0);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.sub   = s;
      e     = model(a, b, s);
      e.cyc = cyc + 1 + NIBBLES;
      q.push_back(e);
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      bus.sub   = 1'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", 1, 0);
      #1;
   endtask

   task automatic expect_final(input string name, input logic [W-1:0] r, input logic c, input logic o);
      chk({name, "_result"}, bus.result, r);
      chk({name, "_cout"}, bus.cout, c);
      chk({name, "_ovf"}, bus.ovf, o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      failures  = 0;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      rst       = 1'b1;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_cout", bus.cout, 0);
      chk("rst_ovf", bus.ovf, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      start_op(16'h1234, 16'h0FCD, 1'b0);
      drain();
      expect_final("add_basic", 16'h2201, 1'b0, 1'b0);

      start_op(16'hFFFF, 16'h0001, 1'b0);
      drain();
      expect_final("add_carry", 16'h0000, 1'b1, 1'b0);

      start_op(16'h0005, 16'h0007, 1'b1);
      drain();
      expect_final("sub_borrow", 16'hFFFE, 1'b0, 1'b0);

      start_op(16'h7FFF, 16'h0001, 1'b0);
      drain();
`ifdef NIBBLE_ADDSUB_SAT_EN
      expect_final("add_ovf", 16'h7FFF, 1'b0, 1'b1);
`else
      expect_final("add_ovf", 16'h8000, 1'b0, 1'b1);
`endif

      start_op(16'h8000, 16'h0001, 1'b1);
      drain();
`ifdef NIBBLE_ADDSUB_SAT_EN
      expect_final("sub_ovf", 16'h8000, 1'b1, 1'b1);
`else
      expect_final("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
`endif

      // Start while busy is ignored; start in the done cycle is accepted.
      start_op(16'h1111, 16'h2222, 1'b0);
      @(posedge clk); #1;
      chk("busy_before_ignored", bus.busy, 1);
      bus.start = 1'b1;
      bus.a     = 16'hFFFF;
      bus.b     = 16'hFFFF;
      bus.sub   = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      start_op(16'h0001, 16'h0001, 1'b0);
      drain();
      expect_final("back_to_back", 16'h0002, 1'b0, 1'b0);

      // Async reset mid-operation abandons it with no done pulse.
      start_op(16'hAAAA, 16'h5555, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      q.delete();
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_result", bus.result, 0);
      chk("midrst_cout", bus.cout, 0);
      chk("midrst_ovf", bus.ovf, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      start_op(16'h00F0, 16'h0010, 1'b0);
      drain();
      expect_final("after_rst", 16'h0100, 1'b0, 1'b0);

      // Random operations with random gaps; some land back-to-back in FIN.
      for (int i = 0; i < 60; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 3) == 0) ra = {1'b0, {(W-1){1'b1}}};
         if ($urandom_range(0, 3) == 0) rb = {1'b1, {(W-1){1'b0}}};
         start_op(ra, rb, 1'($urandom));
         repeat ($urandom_range(0, 6)) @(posedge clk);
      end
      drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
